uart_mmio: RTL and testbench

MMIO UART peripheral behind the data-memory MMIO decode. The CPU writes TX bytes at 0x1000_0000. It reads RX bytes at 0x1000_0000 and status {tx_busy, rx_valid} at 0x1000_0004. This block serialises TX bytes onto `txd`, deserialises `rxd` into a show-ahead RX FIFO, and drives the status and data lines consumed by the memory stage.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_mmio.sv | 174 +++++++++++++++++
 tb/tb_uart_mmio.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, clocks-per-bit helper and
// the MMIO addresses used by the memory-stage decode.
package uart_pkg;

    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic int calc_cpb(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead circular RX FIFO with count register and sticky overrun flag.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       valid,
    output logic       overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        valid   = !empty;
        head    = empty ? '0 : mem[rptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/uart_mmio.sv
// MMIO UART: 8N1 transmitter and receiver FSMs feeding a show-ahead RX FIFO.
// The receiver's push strobe is registered, so a byte lands in the FIFO one cycle after its stop sample.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BAUD     = 115_200,
    parameter int RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_tx_data,
    input  logic       uart_tx_we,
    output logic       uart_tx_busy,
    input  logic       uart_rx_re,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       rx_overrun,
    output logic       txd,
    input  logic       rxd
);

    localparam int CPB = calc_cpb(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state     <= TX_IDLE;
            tx_cnt       <= '0;
            tx_idx       <= '0;
            tx_shift     <= '0;
            txd          <= 1'b1;
            uart_tx_busy <= 1'b0;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (uart_tx_we) begin
                        tx_shift     <= uart_tx_data;
                        tx_cnt       <= '0;
                        tx_idx       <= '0;
                        txd          <= 1'b0;
                        uart_tx_busy <= 1'b1;
                        tx_state     <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        txd      <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            // Shift so the next data bit is always at [1] when it goes out.
                            tx_idx   <= tx_idx + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            txd      <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt       <= '0;
                        uart_tx_busy <= 1'b0;
                        tx_state     <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic rx_sync1;
    logic rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync1 <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rx_sync1 <= rxd;
            rxs      <= rx_sync1;
        end
    end

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic          rx_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_push  <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    if (!rxs) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[7:1]};
                        if (rx_idx == 3'd7) rx_state <= RX_STOP;
                        else                rx_idx   <= rx_idx + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        // Leaving at mid-stop-bit gives half a bit of slack before the next start edge.
                        rx_cnt   <= '0;
                        rx_push  <= rxs;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (uart_rx_re),
        .head      (uart_rx_data),
        .valid     (uart_rx_valid),
        .overrun   (rx_overrun)
    );

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio at CPB=16 and RX_DEPTH=4, using a
// frame-level TX model and a queue-based RX FIFO model.
module tb_uart_mmio;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] uart_tx_data;
    logic       uart_tx_we;
    logic       uart_tx_busy;
    logic       uart_rx_re;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       rx_overrun;
    logic       txd;
    logic       rxd;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] model_q[$];
    logic       model_ovr;

    always #5 clk = ~clk;

    uart_mmio #(
        .CLK_HZ   (16),
        .BAUD     (1),
        .RX_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_we    (uart_tx_we),
        .uart_tx_busy  (uart_tx_busy),
        .uart_rx_re    (uart_rx_re),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .rx_overrun    (rx_overrun),
        .txd           (txd),
        .rxd           (rxd)
    );

    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else                        model_ovr = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; uart_tx_we = 1'b0; uart_tx_data = '0; uart_rx_re = 1'b0; rxd = 1'b1;
        model_q.delete(); model_ovr = 1'b0;
        #1;
        n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_cmp++; if (uart_tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", uart_tx_busy); end
        n_cmp++; if (uart_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", uart_rx_valid); end
        n_cmp++; if (uart_rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", uart_rx_data); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    // Write strobe in cycle 0; optional ignored write in cycle 50; checks cycles 1..171.
    task automatic test_tx(input logic [7:0] b, input bit extra_we, input logic [7:0] extra_b);
        logic [9:0] frame;
        logic       exp_busy;
        logic       exp_txd;
        int         c;
        frame = {1'b1, b, 1'b0};
        for (int k = 0; k <= 170; k++) begin
            @(negedge clk);
            uart_tx_we   = (k == 0) || (extra_we && k == 50);
            uart_tx_data = (k == 0) ? b : extra_b;
            @(posedge clk); #1;
            c = k + 1;
            exp_busy = (c >= 1) && (c <= 10 * CPB);
            exp_txd  = exp_busy ? frame[(c - 1) / CPB] : 1'b1;
            n_cmp++;
            if (uart_tx_busy !== exp_busy) begin
                n_fail++; $display("FAIL tx_busy byte=%h cycle=%0d: got %b want %b", b, c, uart_tx_busy, exp_busy);
            end
            n_cmp++;
            if (txd !== exp_txd) begin
                n_fail++; $display("FAIL tx_txd byte=%h cycle=%0d: got %b want %b", b, c, txd, exp_txd);
            end
        end
    endtask

    // Drives one frame on rxd; optionally pulses uart_rx_re before the edge at offset pop_at.
    task automatic send_frame(input logic [7:0] b, input logic stopb, input int pop_at, output int rise);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        rise = -1;
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            rxd        = f[c / CPB];
            uart_rx_re = (c == pop_at);
            if (c == pop_at && model_q.size() > 0) begin
                n_cmp++;
                if (uart_rx_data !== model_q[0]) begin
                    n_fail++; $display("FAIL rx_pop_during_push: got %h want %h", uart_rx_data, model_q[0]);
                end
                void'(model_q.pop_front());
            end
            @(posedge clk); #1;
            if (rise < 0 && uart_rx_valid) rise = c;
        end
        @(negedge clk) uart_rx_re = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic       ev;
        logic [7:0] ed;
        @(negedge clk);
        ev = model_q.size() > 0;
        ed = ev ? model_q[0] : 8'h00;
        n_cmp++; if (uart_rx_valid !== ev) begin n_fail++; $display("FAIL %s_valid: got %b want %b", name, uart_rx_valid, ev); end
        n_cmp++; if (uart_rx_data !== ed) begin n_fail++; $display("FAIL %s_data: got %h want %h", name, uart_rx_data, ed); end
        uart_rx_re = 1'b1;
        @(negedge clk);
        uart_rx_re = 1'b0;
        if (ev) void'(model_q.pop_front());
        ev = model_q.size() > 0;
        ed = ev ? model_q[0] : 8'h00;
        n_cmp++; if (uart_rx_valid !== ev) begin n_fail++; $display("FAIL %s_after_valid: got %b want %b", name, uart_rx_valid, ev); end
        n_cmp++; if (uart_rx_data !== ed) begin n_fail++; $display("FAIL %s_after_data: got %h want %h", name, uart_rx_data, ed); end
    endtask

    task automatic idle_rx(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) rxd = 1'b1;
        end
    endtask

    // Pop strobe coincides with the push landing in an empty FIFO: the pop must be ignored.
    task automatic test_rx_latency;
        int rise;
        send_frame(8'h5A, 1'b1, 155, rise);
        model_push(8'h5A);
        n_cmp++; if (rise !== 155) begin n_fail++; $display("FAIL rx_latency: got %0d want 155", rise); end
        pop_check("rx_5a");
        idle_rx(20);
    endtask

    task automatic test_rx_random;
        int         rise;
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, -1, rise);
            model_push(b);
        end
        while (model_q.size() > 0) pop_check("rx_rand");
        pop_check("rx_empty_pop");
        idle_rx(20);
    endtask

    // Fill the FIFO, then pop in the very cycle the fifth byte lands.
    task automatic test_full_push_pop;
        int         rise;
        logic [7:0] b;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, (i == DEPTH) ? 155 : -1, rise);
            model_push(b);
        end
        n_cmp++; if (rx_overrun !== model_ovr) begin n_fail++; $display("FAIL full_pushpop_overrun: got %b want %b", rx_overrun, model_ovr); end
        while (model_q.size() > 0) pop_check("full_pushpop");
        idle_rx(20);
    endtask

    task automatic test_glitch_framing;
        int rise;
        @(negedge clk) rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        idle_rx(40);
        n_cmp++; if (uart_rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", uart_rx_valid); end
        send_frame(8'($urandom), 1'b0, -1, rise);
        idle_rx(40);
        n_cmp++; if (rise !== -1) begin n_fail++; $display("FAIL framing_push: valid rose at %0d want never", rise); end
        n_cmp++; if (uart_rx_valid !== 1'b0) begin n_fail++; $display("FAIL framing_valid: got %b want 0", uart_rx_valid); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL framing_overrun: got %b want 0", rx_overrun); end
    endtask

    task automatic test_overrun;
        int rise;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, -1, rise);
            model_push(8'(i));
        end
        n_cmp++; if (rx_overrun !== model_ovr) begin n_fail++; $display("FAIL overrun_flag: got %b want %b", rx_overrun, model_ovr); end
        for (int i = 0; i < DEPTH; i++) pop_check("overrun_pop");
        n_cmp++; if (uart_rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_drained: got %b want 0", uart_rx_valid); end
        n_cmp++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", rx_overrun); end
        idle_rx(10);
    endtask

    task automatic test_reset_mid_tx;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            uart_tx_we   = (k == 0);
            uart_tx_data = 8'h00;
        end
        @(posedge clk); #1;
        n_cmp++; if (uart_tx_busy !== 1'b1) begin n_fail++; $display("FAIL midtx_busy_before: got %b want 1", uart_tx_busy); end
        n_cmp++; if (txd !== 1'b0) begin n_fail++; $display("FAIL midtx_txd_before: got %b want 0", txd); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL midtx_txd_reset: got %b want 1", txd); end
        n_cmp++; if (uart_tx_busy !== 1'b0) begin n_fail++; $display("FAIL midtx_busy_reset: got %b want 0", uart_tx_busy); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL midtx_overrun_reset: got %b want 0", rx_overrun); end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        model_q.delete(); model_ovr = 1'b0;
        test_tx(8'($urandom), 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_tx(8'hA5, 1'b1, 8'h3C);
        test_tx(8'($urandom), 1'b1, 8'($urandom));
        test_rx_latency();
        test_rx_random();
        test_full_push_pop();
        test_glitch_framing();
        test_overrun();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
